// File: rtl/instr_cache_refill.sv
// Instruction-cache miss/refill engine: fetches one line as a fixed burst of beats,
// assembles it, and presents it as a single-cycle fill write to the tag/data arrays.
module instr_cache_refill #(
  parameter int unsigned PADDR_WIDTH = 32,
  parameter int unsigned LINE_BYTES  = 64,
  parameter int unsigned BEAT_BYTES  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_miss_req,
  input  logic [PADDR_WIDTH-1:0]   i_miss_paddr,
  output logic                     o_miss_avail,
  output logic                     o_mem_req,
  output logic [PADDR_WIDTH-1:0]   o_mem_addr,
  input  logic                     i_mem_ack,
  input  logic                     i_mem_data_valid,
  input  logic [8*BEAT_BYTES-1:0]  i_mem_data,
  input  logic                     i_mem_err,
  output logic                     o_fill_valid,
  output logic [PADDR_WIDTH-1:0]   o_fill_paddr,
  output logic [8*LINE_BYTES-1:0]  o_fill_data,
  output logic                     o_fill_err
);

  localparam int unsigned BEATS  = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned OFS    = $clog2(LINE_BYTES);
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BEAT_W = 8 * BEAT_BYTES;
  localparam int unsigned LINE_W = 8 * LINE_BYTES;

  typedef enum logic [2:0] {StIdle, StReq, StRecv, StDrain, StFill} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [LINE_W-1:0]      line_q;
  logic                   err_q;
  logic [PADDR_WIDTH-1:0] addr_q;

  logic cnt_last;
  logic unused_paddr_lsbs;

  assign cnt_last          = (cnt_q == CNT_W'(BEATS - 1));
  assign unused_paddr_lsbs = ^i_miss_paddr[OFS-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_miss_req && !i_flush) begin
            addr_q  <= {i_miss_paddr[PADDR_WIDTH-1:OFS], {OFS{1'b0}}};
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StReq;
          end
        end
        StReq: begin
          // A flush racing the ack must still swallow the burst memory is now committed to.
          if (i_mem_ack) begin
            state_q <= i_flush ? StDrain : StRecv;
          end else if (i_flush) begin
            state_q <= StIdle;
          end
        end
        StRecv: begin
          if (i_mem_data_valid) begin
            cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
            if (!i_flush) begin
              for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) line_q[b*BEAT_W +: BEAT_W] <= i_mem_data;
              end
              err_q <= err_q | i_mem_err;
            end
            if (cnt_last) begin
              state_q <= i_flush ? StIdle : StFill;
            end else if (i_flush) begin
              state_q <= StDrain;
            end
          end else if (i_flush) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (i_mem_data_valid) begin
            cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_last) state_q <= StIdle;
          end
        end
        StFill: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_miss_avail = (state_q == StIdle);
  assign o_mem_req    = (state_q == StReq);
  assign o_mem_addr   = addr_q;
  assign o_fill_valid = (state_q == StFill) && !i_flush;
  assign o_fill_paddr = addr_q;
  assign o_fill_data  = line_q;
  assign o_fill_err   = err_q;

endmodule

// File: tb/tb_instr_cache_refill.sv
// Bench for instr_cache_refill: table of miss transactions driven through a bench-side memory,
// with expected fills queued at request time and checked whenever the fill strobe fires.
module tb_instr_cache_refill;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_paddr = '0;
  logic         miss_avail;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic         mem_data_valid = 1'b0;
  logic [63:0]  mem_data = '0;
  logic         mem_err = 1'b0;
  logic         fill_valid;
  logic [31:0]  fill_paddr;
  logic [511:0] fill_data;
  logic         fill_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] paddr;
    int          tag;
    bit          gap;
    logic [7:0]  err_mask;
    int          flush_at;  // -1 none, 0..7 at beat k, 8 in FILL, 9 in ack cycle, 10 in REQ
    int          ack_wait;
    bit          hold_req;
  } vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
    logic         err;
  } fill_t;

  fill_t exp_q[$];
  vec_t  vecs[11];

  instr_cache_refill dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_flush          (flush),
    .i_miss_req       (miss_req),
    .i_miss_paddr     (miss_paddr),
    .o_miss_avail     (miss_avail),
    .o_mem_req        (mem_req),
    .o_mem_addr       (mem_addr),
    .i_mem_ack        (mem_ack),
    .i_mem_data_valid (mem_data_valid),
    .i_mem_data       (mem_data),
    .i_mem_err        (mem_err),
    .o_fill_valid     (fill_valid),
    .o_fill_paddr     (fill_paddr),
    .o_fill_data      (fill_data),
    .o_fill_err       (fill_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input int tag, input int k);
    return {32'(tag) * 32'h0101_0101, 32'(k)};
  endfunction

  // Any fill strobe must match the oldest outstanding expected fill.
  always @(negedge clk) begin
    if (!rst && fill_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fill", {480'h0, fill_paddr}, 512'h0);
      end else begin
        fill_t f;
        f = exp_q.pop_front();
        chk("fill_paddr", {480'h0, fill_paddr}, {480'h0, f.addr});
        chk("fill_data", fill_data, f.data);
        chk("fill_err", {511'h0, fill_err}, {511'h0, f.err});
      end
    end
  end

  task automatic run_txn(input vec_t v);
    logic [31:0]  exp_addr;
    logic [511:0] exp_line;
    bit           drained;
    exp_addr = {v.paddr[31:6], 6'b0};
    for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = beat_data(v.tag, k);
    drained = (v.flush_at >= 0 && v.flush_at <= 7) || v.flush_at == 9;
    if (v.flush_at == -1) exp_q.push_back('{exp_addr, exp_line, |v.err_mask});

    miss_req   = 1'b1;
    miss_paddr = v.paddr;
    tick();
    miss_req   = v.hold_req;
    miss_paddr = v.hold_req ? 32'hDEAD_BEEF : 32'h0;
    @(negedge clk);
    chk("mem_req_c1", {511'h0, mem_req}, 512'h1);
    chk("mem_addr", {480'h0, mem_addr}, {480'h0, exp_addr});
    chk("avail_busy", {511'h0, miss_avail}, 512'h0);

    if (v.flush_at == 10) begin
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("req_flush_avail", {511'h0, miss_avail}, 512'h1);
      chk("req_flush_memreq", {511'h0, mem_req}, 512'h0);
      tick();
      return;
    end

    for (int i = 0; i < v.ack_wait; i++) tick();
    mem_ack = 1'b1;
    flush   = (v.flush_at == 9);
    tick();
    mem_ack = 1'b0;
    flush   = 1'b0;

    for (int k = 0; k < 8; k++) begin
      if (v.gap && k > 0) begin
        mem_data_valid = 1'b0;
        flush = (v.flush_at == k);
        tick();
        flush = 1'b0;
      end
      mem_data_valid = 1'b1;
      mem_data       = beat_data(v.tag, k);
      mem_err        = v.err_mask[k];
      flush          = (v.flush_at == k) && !(v.gap && k > 0);
      if (k == 7) miss_req = 1'b0;
      if (v.hold_req && k == 3) begin
        @(negedge clk);
        chk("hold_req_ignored", {510'h0, mem_req, miss_avail}, 512'h0);
      end
      tick();
      mem_data_valid = 1'b0;
      mem_data       = '0;
      mem_err        = 1'b0;
      flush          = 1'b0;
    end
    miss_paddr = '0;

    flush = (v.flush_at == 8);
    @(negedge clk);
    chk("fill_strobe", {511'h0, fill_valid}, {511'h0, v.flush_at == -1});
    chk("avail_after_last", {511'h0, miss_avail}, {511'h0, drained});
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("avail_idle", {511'h0, miss_avail}, 512'h1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected to finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h0000_1234, 0,  1'b0, 8'h00, -1, 2, 1'b0};
    vecs[1]  = '{32'h0000_5678, 1,  1'b1, 8'h00, -1, 1, 1'b0};
    vecs[2]  = '{32'h0001_0FC0, 2,  1'b0, 8'h20, -1, 3, 1'b0};
    vecs[3]  = '{32'h0000_3000, 3,  1'b0, 8'h00, 10, 1, 1'b0};
    vecs[4]  = '{32'h0000_4444, 4,  1'b0, 8'h00, 3,  1, 1'b0};
    vecs[5]  = '{32'h0000_2040, 5,  1'b0, 8'h00, -1, 1, 1'b0};
    vecs[6]  = '{32'h0000_7000, 6,  1'b0, 8'h00, 8,  1, 1'b1};
    vecs[7]  = '{32'h0000_8010, 7,  1'b0, 8'h00, 9,  1, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFF, 8,  1'b1, 8'h81, -1, 1, 1'b0};
    vecs[9]  = '{32'h0000_9000, 9,  1'b1, 8'h00, 4,  2, 1'b0};
    vecs[10] = '{32'h0000_A0C8, 10, 1'b0, 8'h00, 7,  1, 1'b0};

    #1;
    chk("rst_avail", {511'h0, miss_avail}, 512'h1);
    chk("rst_mem_req", {511'h0, mem_req}, 512'h0);
    chk("rst_mem_addr", {480'h0, mem_addr}, 512'h0);
    chk("rst_fill_valid", {511'h0, fill_valid}, 512'h0);
    chk("rst_fill_paddr", {480'h0, fill_paddr}, 512'h0);
    chk("rst_fill_data", fill_data, 512'h0);
    chk("rst_fill_err", {511'h0, fill_err}, 512'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    // Async reset in the middle of a burst returns to idle without waiting for a clock edge.
    miss_req   = 1'b1;
    miss_paddr = 32'h0000_ABC0;
    tick();
    miss_req = 1'b0;
    mem_ack  = 1'b1;
    tick();
    mem_ack        = 1'b0;
    mem_data_valid = 1'b1;
    mem_data       = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    mem_data_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_avail", {511'h0, miss_avail}, 512'h1);
    chk("async_rst_mem_req", {511'h0, mem_req}, 512'h0);
    chk("async_rst_fill_paddr", {480'h0, fill_paddr}, 512'h0);
    chk("async_rst_fill_data", fill_data, 512'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_txn(vecs[0]);

    chk("all_fills_seen", 512'(exp_q.size()), 512'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
